// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  // Controller states: normal issue, or full-pipeline freeze for a multi-cycle unit.
  typedef enum logic [0:0] {
    StRun,
    StFreeze
  } state_e;

  // Register index that never carries a real dependency.
  localparam int unsigned REG_ZERO = 0;

  // Bits needed for a counter that must be able to hold timeout_cyc itself.
  function automatic int unsigned freeze_cnt_w(input int unsigned timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute hazard inputs and pipeline control outputs.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned FLUSH_CNT_W = 16
);
  logic [REG_W-1:0]       id_rs;
  logic [REG_W-1:0]       id_rt;
  logic                   id_uses_rt;
  logic                   ex_mem_read;
  logic [REG_W-1:0]       ex_rt;
  logic                   ex_branch_taken;
  logic                   mc_busy;
  logic                   PCWrite;
  logic                   IF_IDWrite;
  logic                   IF_IDFlush;
  logic                   ID_EXBubble;
  logic                   pipe_freeze;
  logic                   stall_err;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [FLUSH_CNT_W-1:0] flush_count;

  // Pipeline side: supplies hazard conditions, consumes enables.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mc_busy,
    input  PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, pipe_freeze, stall_err,
           stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mc_busy,
    output PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, pipe_freeze, stall_err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use stalls, branch flushes, multi-cycle freezes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned FLUSH_CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned     FcntW   = freeze_cnt_w(TIMEOUT_CYC);
  localparam logic [FcntW-1:0] FcntMax = FcntW'(TIMEOUT_CYC);

  state_e                 state_q, state_d;
  logic                   branch_pend_q, branch_pend_d;
  logic [FcntW-1:0]       freeze_cnt_q, freeze_cnt_d;
  logic                   stall_err_q, stall_err_d;
  logic                   load_use;
  logic                   branch_eff;
  logic                   pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  assign load_use = bus.ex_mem_read && (bus.ex_rt != REG_W'(REG_ZERO)) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  // A branch that resolved while frozen is replayed on the release cycle.
  assign branch_eff = bus.ex_branch_taken | ((state_q == StFreeze) & branch_pend_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: freeze follows mc_busy, release lasts exactly one cycle of decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (bus.mc_busy) state_d = StFreeze;
      StFreeze: if (!bus.mc_busy) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // Hazard outputs: freeze > flush > load-use stall > normal; all low in reset.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    if (rst) begin
      freeze = 1'b0;
    end else if (bus.mc_busy) begin
      freeze = 1'b1;
    end else if (branch_eff) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Pending branch and freeze-duration tracking.
  always_comb begin
    branch_pend_d = 1'b0;
    freeze_cnt_d  = freeze_cnt_q;
    if (bus.mc_busy) begin
      if (state_q == StRun) begin
        branch_pend_d = bus.ex_branch_taken;
        freeze_cnt_d  = '0;
      end else begin
        branch_pend_d = branch_pend_q | bus.ex_branch_taken;
        if (freeze_cnt_q != FcntMax) freeze_cnt_d = freeze_cnt_q + FcntW'(1);
      end
    end
    stall_err_d = stall_err_q | (freeze_cnt_d == FcntMax);
  end

  // Pending branch, freeze counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_pend_q <= 1'b0;
      freeze_cnt_q  <= '0;
      stall_err_q   <= 1'b0;
    end else begin
      branch_pend_q <= branch_pend_d;
      freeze_cnt_q  <= freeze_cnt_d;
      stall_err_q   <= stall_err_d;
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .count (flush_cnt)
  );

  assign bus.PCWrite      = pc_write;
  assign bus.IF_IDWrite   = if_id_write;
  assign bus.IF_IDFlush   = if_id_flush;
  assign bus.ID_EXBubble  = id_ex_bubble;
  assign bus.pipe_freeze  = freeze;
  assign bus.stall_err    = stall_err_q & ~rst;
  assign bus.stall_cycles = rst ? '0 : stall_cnt;
  assign bus.flush_count  = rst ? '0 : flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (TIMEOUT_CYC=8, STALL_CNT_W=4).
module tb_hazard_ctrl;
  localparam int unsigned RegW = 5;
  localparam int unsigned Tmo  = 8;
  localparam int unsigned ScW  = 4;
  localparam int unsigned FcW  = 16;

  // Output vector {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, pipe_freeze}
  localparam logic [4:0] ONorm  = 5'b11000;
  localparam logic [4:0] OStall = 5'b00010;
  localparam logic [4:0] OFlush = 5'b11110;
  localparam logic [4:0] OFrz   = 5'b00001;
  localparam logic [4:0] OZero  = 5'b00000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(RegW), .STALL_CNT_W(ScW), .FLUSH_CNT_W(FcW)) bus ();

  hazard_ctrl #(
    .REG_W       (RegW),
    .TIMEOUT_CYC (Tmo),
    .STALL_CNT_W (ScW),
    .FLUSH_CNT_W (FcW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [4:0] outs;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs_now();
    return {bus.PCWrite, bus.IF_IDWrite, bus.IF_IDFlush, bus.ID_EXBubble, bus.pipe_freeze};
  endfunction

  task automatic drive(input logic busy, input logic br, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt);
    bus.mc_busy         = busy;
    bus.ex_branch_taken = br;
    bus.ex_mem_read     = mr;
    bus.ex_rt           = ert;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rt      = urt;
  endtask

  // One cycle: drive at negedge, check combinational outputs, then post-edge state.
  task automatic step(input string tag, input logic busy, input logic br, input logic mr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] exp_outs, input logic exp_err);
    exp_t e;
    drive(busy, br, mr, ert, rs, rt, urt);
    e.tag  = tag;
    e.outs = exp_outs;
    sb.push_back(e);
    if (!exp_outs[4] && m_stall < 15) m_stall++;
    if (exp_outs[2] && m_flush < 65535) m_flush++;
    #1;
    e = sb.pop_front();
    chk({e.tag, "/outs"}, 32'(outs_now()), 32'(e.outs));
    @(posedge clk);
    #1;
    chk({tag, "/stall_cycles"}, 32'(bus.stall_cycles), m_stall);
    chk({tag, "/flush_count"}, 32'(bus.flush_count), m_flush);
    chk({tag, "/stall_err"}, 32'(bus.stall_err), 32'(exp_err));
    @(negedge clk);
  endtask

  // Reset with arbitrary inputs applied; everything must read zero while rst is high.
  task automatic do_reset(input string tag, input logic busy, input logic br);
    rst = 1'b1;
    drive(busy, br, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
    #1;
    chk({tag, "/rst_outs"}, 32'(outs_now()), 32'(OZero));
    chk({tag, "/rst_stall"}, 32'(bus.stall_cycles), 32'd0);
    chk({tag, "/rst_err"}, 32'(bus.stall_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    do_reset("init", 1'b0, 1'b0);

    // Basic hazard decode
    step("normal",    0, 0, 0, 5'd0, 5'd1, 5'd2, 1, ONorm,  0);
    step("lu_rs",     0, 0, 1, 5'd5, 5'd5, 5'd2, 0, OStall, 0);
    step("lu_rt",     0, 0, 1, 5'd7, 5'd1, 5'd7, 1, OStall, 0);
    step("rt_unused", 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, ONorm,  0);
    step("lu_r0",     0, 0, 1, 5'd0, 5'd0, 5'd0, 1, ONorm,  0);
    step("no_load",   0, 0, 0, 5'd5, 5'd5, 5'd5, 1, ONorm,  0);
    step("br_lu",     1'b0, 1'b1, 1, 5'd5, 5'd5, 5'd2, 0, OFlush, 0);
    step("br_only",   0, 1, 0, 5'd0, 5'd1, 5'd2, 0, OFlush, 0);

    // Branch pulse in the second freeze cycle is replayed on release
    do_reset("rst_bf", 0, 0);
    step("bf_frz1", 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFrz,   0);
    step("bf_frz2", 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, OFrz,   0);
    step("bf_frz3", 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFrz,   0);
    step("bf_frz4", 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFrz,   0);
    step("bf_rel",  0, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFlush, 0);
    step("bf_post", 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, ONorm,  0);

    // Branch on the freeze entry cycle is also held
    step("be_frz",  1, 1, 0, 5'd0, 5'd1, 5'd2, 0, OFrz,   0);
    step("be_rel",  0, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFlush, 0);

    // Load-use is ignored while frozen and re-evaluated on release
    do_reset("rst_fl", 0, 0);
    step("fl_frz1", 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, OFrz,   0);
    step("fl_frz2", 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, OFrz,   0);
    step("fl_rel",  0, 0, 1, 5'd4, 5'd4, 5'd0, 0, OStall, 0);
    step("fl_post", 0, 0, 0, 5'd0, 5'd4, 5'd0, 0, ONorm,  0);

    // Timeout: entry edge clears, the 8th in-freeze edge sets the sticky flag
    do_reset("rst_to", 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step($sformatf("to_frz%0d", k), 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFrz, (k >= 9));
    end
    step("to_rel",   0, 0, 0, 5'd0, 5'd1, 5'd2, 0, ONorm, 1);
    step("to_hold",  0, 0, 1, 5'd6, 5'd6, 5'd2, 0, OStall, 1);
    do_reset("rst_to2", 0, 0);
    step("to_clear", 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, ONorm, 0);

    // Stall counter saturation at 15
    do_reset("rst_sat", 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step($sformatf("sat%0d", k), 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, OStall, 0);
    end

    // Reset in the middle of a freeze drops the pending branch
    do_reset("rst_mf0", 0, 0);
    step("mf_frz1", 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, OFrz, 0);
    step("mf_frz2", 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, OFrz, 0);
    do_reset("rst_mf", 1, 1);
    step("mf_post", 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, ONorm, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
